// File: rtl/cam_fill_pkg.sv
// Shared types for the CAM lookup/fill controller.
package cam_fill_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, RESP} fill_state_t;
  localparam int STAT_W = 16;
endpackage

// File: rtl/cam_fill_if.sv
// Request/response handshake between a requester (master) and cam_fill_ctrl (slave).
interface cam_fill_if #(
  parameter int TAG_SZ = 8,
  parameter int BITS   = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [TAG_SZ-1:0] req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [BITS-1:0]   resp_data;
  logic              resp_hit;

  modport master (output req_valid, req_tag, resp_ready,
                  input  req_ready, resp_valid, resp_data, resp_hit);
  modport slave  (input  req_valid, req_tag, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_hit);
endinterface

// File: rtl/cam_fill_victim_ptr.sv
// Round-robin victim slot pointer; wraps on explicit compare so any WORDS works.
module cam_victim_ptr #(
  parameter int WORDS     = 8,
  parameter int ADDR_LEFT = $clog2(WORDS)-1
)(
  input  logic             clk,
  input  logic             rst_,
  input  logic             adv,
  output logic [ADDR_LEFT:0] ptr
);
  localparam int PW = ADDR_LEFT + 1;
  localparam logic [ADDR_LEFT:0] LAST = PW'(WORDS - 1);

  logic [ADDR_LEFT:0] r_ptr;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      r_ptr <= '0;
    else if (adv)
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  end

  assign ptr = r_ptr;
endmodule

// File: rtl/cam_fill_ctrl.sv
// Lookup/fill controller in front of the tag CAM: hits return CAM data, misses fetch,
// write a round-robin victim, then respond. Define CAM_FILL_STATS_EN for hit/miss/full status.
module cam_fill_ctrl
  import cam_fill_pkg::*;
#(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int TAG_SZ    = 8,
  parameter int ADDR_LEFT = $clog2(WORDS)-1
)(
  input  logic                clk,
  input  logic                rst_,
  cam_fill_if.slave           bus,
  output logic [TAG_SZ-1:0]   check_tag,
  input  logic                found_it,
  input  logic [BITS-1:0]     cam_data,
  input  logic                cam_full,
  output logic                write_,
  output logic [ADDR_LEFT:0]  w_addr,
  output logic [BITS-1:0]     wdata,
  output logic [TAG_SZ-1:0]   new_tag,
  output logic                new_valid,
  output logic                mem_req,
  output logic [TAG_SZ-1:0]   mem_tag,
  input  logic                mem_ack,
  input  logic [BITS-1:0]     mem_rdata
`ifdef CAM_FILL_STATS_EN
  ,
  output logic [STAT_W-1:0]   hit_cnt,
  output logic [STAT_W-1:0]   miss_cnt,
  output logic                full_seen
`endif
);
  fill_state_t        r_state;
  logic [TAG_SZ-1:0]  r_tag;
  logic [BITS-1:0]    r_fill;
  logic [BITS-1:0]    r_resp_data;
  logic               r_resp_hit;
  logic               r_resp_valid;
  logic               r_req_ready;
  logic               r_write_n;
  logic               r_new_valid;
  logic               r_mem_req;
  logic [ADDR_LEFT:0] w_victim;
  logic               w_adv;

  // Victim advances on the single FILL cycle, after w_addr has been used.
  assign w_adv = (r_state == FILL);

  cam_victim_ptr #(.WORDS(WORDS), .ADDR_LEFT(ADDR_LEFT)) u_victim (
    .clk  (clk),
    .rst_ (rst_),
    .adv  (w_adv),
    .ptr  (w_victim)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_fill       <= '0;
      r_resp_data  <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
      r_write_n    <= 1'b1;
      r_new_valid  <= 1'b0;
      r_mem_req    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid && r_req_ready) begin
          r_tag       <= bus.req_tag;
          r_req_ready <= 1'b0;
          r_state     <= LOOKUP;
        end
        LOOKUP: if (found_it) begin
          r_resp_data  <= cam_data;
          r_resp_hit   <= 1'b1;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end else begin
          r_mem_req <= 1'b1;
          r_state   <= MISS;
        end
        MISS: if (mem_ack && r_mem_req) begin
          r_mem_req   <= 1'b0;
          r_fill      <= mem_rdata;
          r_resp_data <= mem_rdata;
          r_resp_hit  <= 1'b0;
          r_write_n   <= 1'b0;
          r_new_valid <= 1'b1;
          r_state     <= FILL;
        end
        FILL: begin
          r_write_n    <= 1'b1;
          r_new_valid  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: if (bus.resp_ready) begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_hit   = r_resp_hit;
  // tag_q doubles as the CAM probe, the fetch tag and the fill tag.
  assign check_tag = r_tag;
  assign mem_tag   = r_tag;
  assign new_tag   = r_tag;
  assign mem_req   = r_mem_req;
  assign write_    = r_write_n;
  assign new_valid = r_new_valid;
  assign w_addr    = w_victim;
  assign wdata     = r_fill;

`ifdef CAM_FILL_STATS_EN
  logic [STAT_W-1:0] r_hit_cnt, r_miss_cnt;
  logic              r_full_seen;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_full_seen <= 1'b0;
    end else begin
      if (r_state == LOOKUP) begin
        if (found_it) begin
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
        end else begin
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
      if (cam_full) r_full_seen <= 1'b1;
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign full_seen = r_full_seen;
`else
  logic w_unused_full;
  assign w_unused_full = cam_full;
`endif
endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Bench for cam_fill_ctrl: CAM and memory models, a vector table, corner sequences and
// a randomized run against a slot/tag reference model.
module tb_cam_fill_ctrl;
  localparam int WORDS = 8;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  cam_fill_if #(.TAG_SZ(8), .BITS(8)) bus ();

  logic [7:0] check_tag, cam_data, wdata, new_tag, mem_tag, mem_rdata;
  logic       found_it, cam_full, write_, new_valid, mem_req, mem_ack;
  logic [2:0] w_addr;
`ifdef CAM_FILL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
  logic        full_seen;
`endif

  cam_fill_ctrl #(.WORDS(WORDS), .BITS(8), .TAG_SZ(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .bus       (bus),
    .check_tag (check_tag),
    .found_it  (found_it),
    .cam_data  (cam_data),
    .cam_full  (cam_full),
    .write_    (write_),
    .w_addr    (w_addr),
    .wdata     (wdata),
    .new_tag   (new_tag),
    .new_valid (new_valid),
    .mem_req   (mem_req),
    .mem_tag   (mem_tag),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CAM_FILL_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .full_seen (full_seen)
`endif
  );

  // Behavioural tag CAM sharing rst_.
  logic [7:0] c_tag [WORDS];
  logic [7:0] c_dat [WORDS];
  logic       c_vld [WORDS];

  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int k = 0; k < WORDS; k++) begin
        c_tag[k] <= '0; c_dat[k] <= '0; c_vld[k] <= 1'b0;
      end
    end else if (!write_ && new_valid) begin
      c_tag[w_addr] <= new_tag; c_dat[w_addr] <= wdata; c_vld[w_addr] <= 1'b1;
    end
  end

  always_comb begin
    found_it = 1'b0; cam_data = '0; cam_full = 1'b1;
    for (int k = 0; k < WORDS; k++) begin
      if (c_vld[k] && c_tag[k] == check_tag) begin found_it = 1'b1; cam_data = c_dat[k]; end
      if (!c_vld[k]) cam_full = 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // One full transaction; memory answers after dly cycles of mem_req, consumer stalls 'stall' cycles.
  task automatic run_req(input string nm, input logic [7:0] tag, input int dly, input logic [7:0] rd,
                         input int stall, input logic exp_hit, input logic [7:0] exp_data,
                         input logic [2:0] exp_addr);
    logic got, done, acked, filled, hit;
    logic [7:0] data, ntag, wd;
    logic [2:0] waddr;
    int st, mseen, lat, ack_at;
    got = 0; done = 0; acked = 0; filled = 0; hit = 0; data = 0; ntag = 0; wd = 0; waddr = 0;
    st = 0; mseen = 0; lat = -1; ack_at = -100;
    @(negedge clk);
    chk({nm, "/req_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_tag = tag; bus.resp_ready = (stall == 0);
    @(posedge clk);
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (i == 1) bus.req_valid = 1'b0;
      if (got) begin
        if (st < stall) begin
          st++;
          chk({nm, "/stall_hold"}, {bus.resp_valid, bus.req_ready, bus.resp_data}, {1'b1, 1'b0, data});
          bus.req_valid = 1'b1; bus.req_tag = ~tag;
          if (st == stall) bus.resp_ready = 1'b1;
        end else begin
          done = 1;
          chk({nm, "/release"}, {bus.resp_valid, bus.req_ready, mem_req}, 3'b010);
          bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        end
      end else begin
        if (!write_ && !filled) begin
          filled = 1; waddr = w_addr; ntag = new_tag; wd = wdata;
          chk({nm, "/new_valid"}, new_valid, 1);
        end
        if (bus.resp_valid) begin
          got = 1; lat = i; hit = bus.resp_hit; data = bus.resp_data;
        end else if (mem_req && !acked) begin
          mseen++;
          if (mseen == 1) chk({nm, "/mem_tag"}, mem_tag, tag);
          if (mseen == dly) begin mem_ack = 1'b1; mem_rdata = rd; acked = 1; ack_at = i; end
        end
      end
    end
    chk({nm, "/done"}, done, 1);
    if (!done) do_reset();
    else begin
      chk({nm, "/hit"}, hit, exp_hit);
      chk({nm, "/data"}, data, exp_data);
      if (exp_hit) begin
        chk({nm, "/hit_lat"}, lat, 2);
        chk({nm, "/no_mem_no_fill"}, {mseen != 0, filled}, 0);
      end else begin
        chk({nm, "/miss_lat"}, lat, ack_at + 2);
        chk({nm, "/fill"}, {filled, waddr, ntag, wd}, {1'b1, exp_addr, tag, rd});
      end
    end
  endtask

  typedef struct {
    logic [7:0] tag;
    int         dly;
    logic [7:0] rd;
    logic       rst_before;
    logic       exp_hit;
    logic [7:0] exp_data;
    logic [2:0] exp_addr;
  } vec_t;

  vec_t tbl [13];

  logic [7:0] m_tag [WORDS];
  logic [7:0] m_dat [WORDS];
  logic       m_vld [WORDS];

  initial begin
    logic [7:0] tag, rd, edata;
    logic       ehit, bad;
    int         slot, fills;

    rst_ = 1'b0; bus.req_valid = 1'b0; bus.req_tag = '0; bus.resp_ready = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst/req_ready", bus.req_ready, 1);
    chk("rst/resp_valid", bus.resp_valid, 0);
    chk("rst/resp_hit", bus.resp_hit, 0);
    chk("rst/resp_data", bus.resp_data, 0);
    chk("rst/write_", write_, 1);
    chk("rst/new_valid", new_valid, 0);
    chk("rst/mem_req", mem_req, 0);
    chk("rst/check_tag", check_tag, 0);
    chk("rst/w_addr", w_addr, 0);
    chk("rst/wdata", wdata, 0);
    chk("rst/new_tag", new_tag, 0);
    chk("rst/mem_tag", mem_tag, 0);
    @(negedge clk);
    rst_ = 1'b1;

    tbl[0] = '{8'h3C, 3, 8'hA5, 1'b0, 1'b0, 8'hA5, 3'd0};
    tbl[1] = '{8'h3C, 1, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0};
    for (int k = 0; k < 9; k++)
      tbl[2+k] = '{8'(8'h10 + k), 2, 8'(~(8'h10 + k)), (k == 0), 1'b0, 8'(~(8'h10 + k)), 3'(k % 8)};
    tbl[11] = '{8'h10, 2, 8'h77, 1'b0, 1'b0, 8'h77, 3'd1};
    tbl[12] = '{8'h18, 1, 8'h00, 1'b0, 1'b1, 8'hE7, 3'd0};

    for (int t = 0; t < 13; t++) begin
      if (tbl[t].rst_before) do_reset();
      run_req($sformatf("vec%0d", t), tbl[t].tag, tbl[t].dly, tbl[t].rd, 0,
              tbl[t].exp_hit, tbl[t].exp_data, tbl[t].exp_addr);
    end

    run_req("stall5", 8'h18, 1, 8'h00, 5, 1'b1, 8'hE7, 3'd0);

    // Reset while waiting on memory; a late ack must be ignored.
    do_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_tag = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("rstmiss/in_miss", mem_req, 1);
    rst_ = 1'b0;
    #1;
    chk("rstmiss/async", {mem_req, bus.req_ready, write_, bus.resp_valid}, 4'b0110);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!write_ || bus.resp_valid || mem_req) bad = 1'b1;
    end
    chk("rstmiss/late_ack", bad, 0);

`ifdef CAM_FILL_STATS_EN
    do_reset();
    run_req("st_m0", 8'hA0, 1, 8'h11, 0, 1'b0, 8'h11, 3'd0);
    run_req("st_m1", 8'hA1, 2, 8'h22, 0, 1'b0, 8'h22, 3'd1);
    run_req("st_h0", 8'hA0, 1, 8'h00, 0, 1'b1, 8'h11, 3'd0);
    run_req("st_h1", 8'hA1, 1, 8'h00, 0, 1'b1, 8'h22, 3'd0);
    run_req("st_h2", 8'hA0, 1, 8'h00, 0, 1'b1, 8'h11, 3'd0);
    chk("stats/hit_cnt", hit_cnt, 3);
    chk("stats/miss_cnt", miss_cnt, 2);
    chk("stats/full_pre", full_seen, 0);
    for (int k = 2; k < 8; k++)
      run_req($sformatf("st_f%0d", k), 8'(8'hA0 + k), 1, 8'(k), 0, 1'b0, 8'(k), 3'(k));
    chk("stats/full_seen", full_seen, 1);
`endif

    // Randomized run: the model tracks resident lines and fill count; victim = fills mod WORDS.
    do_reset();
    fills = 0;
    for (int k = 0; k < WORDS; k++) begin m_vld[k] = 1'b0; m_tag[k] = '0; m_dat[k] = '0; end
    for (int r = 0; r < 40; r++) begin
      tag = 8'(8'h40 + $urandom_range(0, 11));
      rd  = 8'($urandom_range(0, 255));
      ehit = 1'b0; edata = rd;
      for (int k = 0; k < WORDS; k++)
        if (m_vld[k] && m_tag[k] == tag) begin ehit = 1'b1; edata = m_dat[k]; end
      slot = fills % WORDS;
      run_req($sformatf("rnd%0d", r), tag, $urandom_range(1, 4), rd, $urandom_range(0, 2),
              ehit, edata, 3'(slot));
      if (!ehit) begin
        m_tag[slot] = tag; m_dat[slot] = rd; m_vld[slot] = 1'b1; fills++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
